// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the single MMIO port between the CPU (port 0) and the LED DMA (port 1).
// Optional feature macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed CPU priority.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int LOCK_MAX    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_ram,
  input  logic [15:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_ram,
  input  logic [15:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        mem_use_ram,
  output logic        mem_load_en,
  output logic        mem_store_en,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic       owner;
  logic [7:0] lock_cnt;
  logic       any_req;
  logic       lock_hit;
  logic       win;
  logic       win_we;
`ifdef ARB_ROUND_ROBIN_EN
  logic       rr_ptr;
`endif

  // Lock rule takes precedence over both fixed priority and round robin.
  always_comb begin
    any_req  = p0_req | p1_req;
    lock_hit = owner & p1_lock & p1_req & (lock_cnt < LOCK_LIM);
    if (lock_hit) begin
      win = 1'b1;
    end else if (p0_req & p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = rr_ptr;
`else
      win = 1'b0;
`endif
    end else begin
      win = p1_req;
    end
    win_we = win ? p1_we : p0_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      owner        <= 1'b0;
      lock_cnt     <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      mem_use_ram  <= 1'b0;
      mem_load_en  <= 1'b0;
      mem_store_en <= 1'b0;
      mem_addr     <= '0;
      mem_in       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr       <= 1'b0;
`endif
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner        <= win;
            mem_addr     <= win ? p1_addr : p0_addr;
            mem_in       <= win ? p1_wdata : p0_wdata;
            mem_use_ram  <= win ? p1_ram : p0_ram;
            mem_store_en <= win_we;
            mem_load_en  <= ~win_we;
            lat_cnt      <= LAT_INIT;
            if (lock_hit) begin
              lock_cnt <= lock_cnt + 8'd1;
            end else if (!win || !p1_lock) begin
              lock_cnt <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr       <= ~win;
`endif
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lat_cnt == 3'd1) begin
            mem_load_en  <= 1'b0;
            mem_store_en <= 1'b0;
            // Stores complete without touching the owner's load data.
            if (mem_load_en) begin
              if (owner) p1_rdata <= mem_out;
              else       p0_rdata <= mem_out;
            end
            if (owner) p1_ack <= 1'b1;
            else       p0_ack <= 1'b1;
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected accesses are queued at stimulus time and
// retired against the MMIO strobes and per-port acks.
module tb_mem_arbiter;

  localparam int LAT  = 3;
  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_ram;
  logic [15:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p1_req, p1_we, p1_ram, p1_lock;
  logic [15:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_use_ram, mem_load_en, mem_store_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_in, mem_out;

  typedef struct {
    logic        port;
    logic        we;
    logic        ram;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] exp_rd[2];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  mem_arbiter #(.MEM_LATENCY(LAT), .LOCK_MAX(LOCK)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_ram(p0_ram), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_ram(p1_ram), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_use_ram(mem_use_ram), .mem_load_en(mem_load_en), .mem_store_en(mem_store_en),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mmio_f(input logic [15:0] a, input logic ram);
    if (!ram && a == 16'h0010) return 32'hDEADBEEF;
    return {(ram ? 16'h5A00 : 16'hC300), a};
  endfunction

  assign mem_out = mmio_f(mem_addr, mem_use_ram);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic ram,
                      input logic [15:0] addr, input logic [31:0] wdata);
    acc_t e;
    e.port  = port;
    e.we    = we;
    e.ram   = ram;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = we ? exp_rd[port] : mmio_f(addr, ram);
    exp_rd[port] = e.rdata;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic ram,
                       input logic [15:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_ram = ram; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_ram = ram; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic single(input logic port, input logic we, input logic ram,
                        input logic [15:0] addr, input logic [31:0] wdata);
    int n;
    bit got;
    push(port, we, ram, addr, wdata);
    drive(port, 1'b1, we, ram, addr, wdata);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (port ? p1_ack : p0_ack) got = 1'b1;
    end
    if (!got) check("single_ack_timeout", 32'd0, 32'd1);
    else      check("single_latency", 32'(n), 32'(LAT + 1));
    drive(port, 1'b0, we, ram, addr, wdata);
    @(negedge clk);
  endtask

  // Wait for n acks on either port, then drop every request during the last ack cycle.
  task automatic run_acks(input int n, input int budget);
    int k;
    int t;
    k = 0;
    t = 0;
    while (k < n && t < budget) begin
      @(negedge clk);
      t++;
      if (p0_ack | p1_ack) k++;
    end
    if (k < n) check("ack_count_timeout", 32'(k), 32'(n));
    p0_req  = 1'b0;
    p1_req  = 1'b0;
    p1_lock = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int          run_len = 0;
  logic        prev_stb = 1'b0;
  logic [15:0] stb_addr;

  always @(negedge clk) begin
    acc_t e;
    if (rst) begin
      run_len  = 0;
      prev_stb = 1'b0;
    end else begin
      check("dual_strobe", 32'(mem_load_en & mem_store_en), 32'd0);
      if (p0_ack & p1_ack) check("dual_ack", 32'd1, 32'd0);
      if (mem_load_en | mem_store_en) begin
        if (!prev_stb) begin
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            check("mem_addr", 32'(mem_addr), 32'(e.addr));
            check("mem_use_ram", 32'(mem_use_ram), 32'(e.ram));
            check("store_strobe", 32'(mem_store_en), 32'(e.we));
            if (e.we) check("mem_in", mem_in, e.wdata);
          end
          stb_addr = mem_addr;
        end else begin
          check("addr_hold", 32'(mem_addr), 32'(stb_addr));
        end
        run_len++;
      end
      if (p0_ack | p1_ack) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 32'(p1_ack), 32'(e.port));
          check("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
          check("strobe_len", 32'(run_len), 32'(LAT));
        end
        run_len = 0;
      end
      prev_stb = mem_load_en | mem_store_en;
    end
  end

  initial begin
    int  t_ack[3];
    int  k;
    int  t;
    bit  seen;
    rst = 1'b1;
    p1_lock = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_p0_ack", 32'(p0_ack), 32'd0);
    check("rst_p1_ack", 32'(p1_ack), 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_in", mem_in, 32'd0);
    check("rst_use_ram", 32'(mem_use_ram), 32'd0);
    check("rst_strobes", 32'({mem_load_en, mem_store_en}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    single(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
    single(1'b1, 1'b1, 1'b1, 16'h0200, 32'h00FF8800);
    check("p0_rdata_held", p0_rdata, 32'hDEADBEEF);

    // Both requesters held; last grant was port 1.
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 1'b0, 16'h0040, 32'h0);
      push(1'b1, 1'b0, 1'b1, 16'h0080, 32'h0);
    end
`else
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 16'h0040, 32'h0);
`endif
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 32'h0);
    run_acks(4, 200);

    // Lock burst: a port-0 grant first so the initial port-1 grant is not a lock grant.
    single(1'b0, 1'b0, 1'b1, 16'h0020, 32'h0);
    for (int i = 0; i < LOCK + 1; i++) push(1'b1, 1'b0, 1'b1, 16'h0400, 32'h0);
    push(1'b0, 1'b0, 1'b0, 16'h0050, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0400, 32'h0);
    p1_lock = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 32'h0);
    run_acks(LOCK + 2, 400);

    // Back-to-back port-0 loads with the request held across acks.
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 16'(16'h0100 + i), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 32'h0);
    k = 0;
    t = 0;
    while (k < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (p0_ack) begin
        t_ack[k] = cyc;
        k++;
        if (k < 3) p0_addr = 16'(16'h0100 + k);
        else       p0_req = 1'b0;
      end
    end
    p0_req = 1'b0;
    if (k < 3) begin
      check("b2b_timeout", 32'(k), 32'd3);
    end else begin
      check("b2b_spacing_1", 32'(t_ack[1] - t_ack[0]), 32'(LAT + 2));
      check("b2b_spacing_2", 32'(t_ack[2] - t_ack[1]), 32'(LAT + 2));
    end
    repeat (2) @(negedge clk);

    // Reset during the second BUSY cycle aborts the access without an ack.
    push(1'b0, 1'b0, 1'b0, 16'h0300, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0);
    repeat (2) @(negedge clk);
    check("pre_abort_strobe", 32'(mem_load_en), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_strobes", 32'({mem_load_en, mem_store_en}), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_p0_rdata", p0_rdata, 32'd0);
    exp_q.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (p0_ack | p1_ack) seen = 1'b1;
    end
    check("no_ack_after_abort", 32'(seen), 32'd0);
    single(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
